// File: rtl/fetch_decode_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Drives the PC to a combinational instruction ROM, registers the fetched
// word, splits it into decode fields, and manages stall, branch redirect
// (flush) and a HALTED state entered on the HALT opcode.
module fetch_decode_stage #(
    parameter int                    PC_WIDTH    = 8,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = 8'h00,
    parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic                   id_valid,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [3:0]             id_opcode,
    output logic [3:0]             id_rd,
    output logic [3:0]             id_rs,
    output logic [3:0]             id_imm4,
    output logic                   halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Fetch stage: program counter
    logic [PC_WIDTH-1:0] pc_p0;
    logic [PC_WIDTH-1:0] pc_d;

    // IF/ID stage: captured instruction and its address
    logic                vld_p1;
    logic                vld_d;
    logic                load_id;
    logic [PC_WIDTH-1:0] pc_p1;
    logic [3:0]          opcode_p1;
    logic [3:0]          rd_p1;
    logic [3:0]          rs_p1;
    logic [3:0]          imm4_p1;

    logic [3:0]          fetch_opcode;

    assign fetch_opcode = imem_data[15:12];

    // State register; leaves HALTED only on a redirect or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register controls; a branch overrides stall and HALTED.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_p0;
        vld_d   = vld_p1;
        load_id = 1'b0;
        if (branch_taken) begin
            // Flush: only the valid bit drops, fields keep stale contents.
            pc_d    = branch_target;
            vld_d   = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (!stall) begin
                load_id = 1'b1;
                vld_d   = 1'b1;
                if (fetch_opcode == HALT_OPCODE) begin
                    // PC parks on the HALT instruction itself.
                    state_d = HALTED;
                end else begin
                    pc_d = pc_p0 + PC_WIDTH'(1);
                end
            end
        end else begin
            // HALTED: emit bubbles, but keep the HALT word while stalled.
            if (!stall) begin
                vld_d = 1'b0;
            end
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_d;
        end
    end

    // IF/ID register: valid bit plus decode fields loaded on a real fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            pc_p1     <= '0;
            opcode_p1 <= '0;
            rd_p1     <= '0;
            rs_p1     <= '0;
            imm4_p1   <= '0;
        end else begin
            vld_p1 <= vld_d;
            if (load_id) begin
                pc_p1     <= pc_p0;
                opcode_p1 <= imem_data[15:12];
                rd_p1     <= imem_data[11:8];
                rs_p1     <= imem_data[7:4];
                imm4_p1   <= imem_data[3:0];
            end
        end
    end

    assign imem_addr = pc_p0;
    assign id_valid  = vld_p1;
    assign id_pc     = pc_p1;
    assign id_opcode = opcode_p1;
    assign id_rd     = rd_p1;
    assign id_rs     = rs_p1;
    assign id_imm4   = imm4_p1;
    assign halted    = (state_q == HALTED);

endmodule
